// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and constants.
// Fetch entries pair an instruction word with the PC it was fetched from.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush beats push and pop.
// An empty FIFO presents an all-zero head so downstream never sees stale words.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    fetch_entry_t  mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_reg != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order
// requests, buffers responses with their PCs and handles EX-stage redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full, fifo_empty;
    logic            grant, push, pop;
    fetch_entry_t    push_entry, head_entry;

    // Credits cover both in-flight requests and buffered words, so every
    // granted response is guaranteed a FIFO slot. Registered values only.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign imem_req_o  = rst_ni && !redirect_i && (credit_used < CREDITS);
    assign imem_addr_o = fetch_pc_reg;
    assign grant       = imem_req_o && imem_gnt_i;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        push             = 1'b0;
        if (redirect_i) begin
            // Everything still in flight belongs to the squashed path.
            fetch_pc_next    = word_align(redirect_pc_i);
            resp_pc_next     = word_align(redirect_pc_i);
            outstanding_next = outstanding_reg - CW'(imem_rvalid_i);
            discard_next     = outstanding_reg - CW'(imem_rvalid_i);
        end else begin
            if (grant) fetch_pc_next = fetch_pc_reg + XLEN'(ILEN_BYTES);
            if (imem_rvalid_i) begin
                if (discard_reg != '0) begin
                    discard_next = discard_reg - CW'(1);
                end else begin
                    push         = 1'b1;
                    resp_pc_next = resp_pc_reg + XLEN'(ILEN_BYTES);
                end
            end
            outstanding_next = outstanding_reg + CW'(grant) - CW'(imem_rvalid_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    assign push_entry = '{instr: imem_rdata_i, pc: resp_pc_reg};
    assign pop        = instr_valid_o && instr_ready_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_i),
        .din    (push_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count),
        .head   (head_entry)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head_entry.instr;
    assign pc_o          = head_entry.pc;

    // The credit rule makes this unreachable; a hit means the credit logic broke.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V pipeline: owns the fetch PC, issues in-order requests to instruction memory, buffers returned words with their PCs in a small FIFO, and presents them to the IF/ID register through a valid/ready handshake. Decode and immediate generation downstream consume `instr_o`; in particular, `instr_o[31:7]` is what feeds immediate extension. EX-stage branch/jump resolution redirects the unit and flushes everything younger.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: FIFO entries, which also bound in-flight requests. Power of two, ≥2.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: request address, word aligned.
- `imem_gnt_i` in 1: request accepted this cycle; only meaningful while `imem_req_o`=1.
- `imem_rvalid_i` in 1: response valid; responses arrive in order, ≥1 cycle after grant.
- `imem_rdata_i` in 32: response instruction word.
- `redirect_i` in 1: taken branch/jump; flush and refetch.
- `redirect_pc_i` in 32: new PC; bits [1:0] are ignored and treated as 0.
- `instr_valid_o` out 1: `instr_o`/`pc_o` valid.
- `instr_ready_i` in 1: IF/ID accepts this cycle.
- `instr_o` out 32: instruction at FIFO head.
- `pc_o` out 32: PC of `instr_o`.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: requests granted but not yet responded.
  - `discard`: responses still to be dropped.
  - FIFO of {instr, pc}.
- Request: `imem_req_o` = !`redirect_i` && (`outstanding` + `fifo_count`) < `DEPTH`, using registered values only. A FIFO pop does not free credit in the same cycle. `imem_addr_o` = `fetch_pc`. On grant: `fetch_pc` += 4, `outstanding` += 1.
- Response, while not redirecting:
  - If `discard` > 0: drop the word and decrement `discard`.
  - Otherwise push {`imem_rdata_i`, `resp_pc`} and increment `resp_pc` by 4.
  - `outstanding` -= 1 in both cases.
  - The credit rule guarantees the FIFO never overflows. A push into a full FIFO is a design error and is asserted against in simulation.
- Output: `instr_valid_o` = FIFO non-empty. Pop on `instr_valid_o` && `instr_ready_i`. Simultaneous push and pop leaves the count unchanged.
- Redirect cycle, which has priority over all else:
  - FIFO is flushed.
  - `fetch_pc` and `resp_pc` are loaded with {`redirect_pc_i`[31:2], 2'b00}.
  - `discard` is set to `outstanding` − `imem_rvalid_i`.
  - A response arriving in the redirect cycle is dropped.
  - No grant can occur, because `imem_req_o`=0.
  - A handshake on the output in the same cycle is still a valid transfer; upstream owns squashing it.
- Back-to-back redirects: each one recomputes `discard` from the current `outstanding`.
- Address wrap: `fetch_pc` and `resp_pc` wrap modulo 2^32 silently.

## Timing
- Reset (async assert, sync release):
  - `fetch_pc` and `resp_pc` = `RESET_PC`; `outstanding`, `discard` and FIFO count = 0.
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `instr_valid_o`=0, `instr_o`=0, `pc_o`=0.
- First request: in the first cycle after `rst_ni` rises.
- Latency: grant in cycle n with `rvalid` in n+1 gives `instr_valid_o` in n+2. The FIFO is registered, so there is no combinational path from `imem_rdata_i` to `instr_o`.
- Throughput: with DEPTH=4, a 1-cycle memory and `instr_ready_i` held high, one instruction per cycle is sustained after fill.
- Redirect to first new request: `imem_req_o` rises the cycle after `redirect_i`. The earliest new `instr_valid_o` is 3 cycles after `redirect_i` with a 1-cycle memory.
- Reset mid-operation: all state clears immediately. In-flight memory responses are the memory's responsibility, because it shares the same reset.

## Structure
- Shared package `riscv_pkg`:
  - `fetch_entry_t` struct {`instr` [31:0], `pc` [31:0]}.
  - `XLEN`=32.
  - Localparam `ILEN_BYTES`=4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`. Ports: push, pop, flush, full, empty, count, head. Flush has priority over push and pop.
- Top level: the fetch PC register, the `outstanding`/`discard` counters, and the request/credit logic.

## Test plan
- Reset with `RESET_PC`=32'h0000_1000 and a 1-cycle memory, `instr_ready_i`=1 → addresses 0x1000, 0x1004, 0x1008… in consecutive cycles; first `instr_valid_o` 2 cycles after the first grant with `pc_o`=0x1000; then one instruction per cycle.
- Hold `instr_ready_i`=0 → FIFO fills to 4 and `imem_req_o` drops once `outstanding`+count=4. Release ready → in-order drain with no lost or duplicated PCs.
- Memory with 3-cycle latency, 2 requests in flight, `redirect_i` with `redirect_pc_i`=0x2002 → both late responses dropped; next request to 0x2000; first output `pc_o`=0x2000.
- `redirect_i` in the same cycle as `imem_rvalid_i`, with `outstanding`=2 → that response dropped, `discard`=1, and the next response is also dropped.
- `fetch_pc`=0xFFFF_FFFC → next request address 0x0000_0000, and `pc_o` wraps identically.
- Assert `rst_ni` low mid-stream with the FIFO at 3 entries → `instr_valid_o` and `imem_req_o` drop immediately; after release, fetch restarts at `RESET_PC`.
